// File: rtl/time_set_ctrl.sv
// time_set_ctrl: mode/setting controller for the digital clock.
// Pauses the timer, edits h/m/s from button pulses, loads the result back,
// holds an hh:mm alarm, and drives the display value and blink mask.
module time_set_ctrl #(
    parameter int unsigned BLINK_HALF = 50_000_000,
    parameter int unsigned ALARM_SEC  = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode_pulse,
    input  logic        up_pulse,
    input  logic        down_pulse,
    input  logic        alarm_pulse,
    input  logic [23:0] time_in,
    output logic        run_en,
    output logic        load,
    output logic [23:0] load_value,
    output logic [23:0] disp_value,
    output logic [5:0]  blank_mask,
    output logic        alarm_en,
    output logic        alarm_active
);

    localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int unsigned SW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [SW-1:0] SEC_LAST   = SW'(ALARM_SEC - 1);

    typedef enum logic [2:0] {
        RUN,
        SET_H,
        SET_M,
        SET_S,
        ALM_H,
        ALM_M
    } state_t;

    state_t          state_q, state_d;
    logic [23:0]     edit_q, edit_d;
    logic [7:0]      alarm_h_q, alarm_h_d;
    logic [7:0]      alarm_m_q, alarm_m_d;
    logic            alarm_en_q, alarm_en_d;
    logic            alarm_active_q, alarm_active_d;
    logic [SW-1:0]   sec_cnt_q, sec_cnt_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            blink_off_q, blink_off_d;
    logic [23:0]     prev_time_q, prev_time_d;
    logic            run_en_q, run_en_d;
    logic            load_q, load_d;
    logic [23:0]     load_value_q, load_value_d;
    logic [23:0]     disp_value_q, disp_value_d;
    logic [5:0]      blank_mask_q, blank_mask_d;

    logic            step_acc;
    logic            any_pulse;
    logic            sec_chg;
    logic            match;

    // Wrapping increment/decrement of one field in 0..maxv.
    function automatic logic [7:0] step_field(input logic [7:0] v,
                                              input logic [7:0] maxv,
                                              input logic       inc);
        logic [7:0] r;
        if (inc) begin
            r = (v >= maxv) ? 8'd0 : v + 8'd1;
        end else begin
            r = ((v == 8'd0) || (v > maxv)) ? maxv : v - 8'd1;
        end
        return r;
    endfunction

    assign step_acc  = (state_q != RUN) && !mode_pulse && (up_pulse || down_pulse);
    assign any_pulse = mode_pulse || up_pulse || down_pulse || alarm_pulse;
    assign sec_chg   = (time_in[7:0] != prev_time_q[7:0]);
    assign match     = (time_in == {alarm_h_q, alarm_m_q, 8'd0}) && (time_in != prev_time_q);

    // Mode sequencing: each mode pulse advances one state around the ring.
    always_comb begin
        state_d = state_q;
        if (mode_pulse) begin
            case (state_q)
                RUN:     state_d = SET_H;
                SET_H:   state_d = SET_M;
                SET_M:   state_d = SET_S;
                SET_S:   state_d = ALM_H;
                ALM_H:   state_d = ALM_M;
                ALM_M:   state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // Field editing, load generation, blink timing and alarm bookkeeping.
    always_comb begin
        edit_d         = edit_q;
        alarm_h_d      = alarm_h_q;
        alarm_m_d      = alarm_m_q;
        alarm_en_d     = alarm_en_q;
        alarm_active_d = alarm_active_q;
        sec_cnt_d      = sec_cnt_q;
        blink_cnt_d    = blink_cnt_q;
        blink_off_d    = blink_off_q;
        prev_time_d    = time_in;
        load_d         = 1'b0;
        load_value_d   = load_value_q;

        if ((state_q == RUN) && (state_d == SET_H)) begin
            edit_d = time_in;
        end

        if (step_acc) begin
            case (state_q)
                SET_H:   edit_d[23:16] = step_field(edit_q[23:16], 8'd23, up_pulse);
                SET_M:   edit_d[15:8]  = step_field(edit_q[15:8],  8'd59, up_pulse);
                SET_S:   edit_d[7:0]   = step_field(edit_q[7:0],   8'd59, up_pulse);
                ALM_H:   alarm_h_d     = step_field(alarm_h_q,     8'd23, up_pulse);
                ALM_M:   alarm_m_d     = step_field(alarm_m_q,     8'd59, up_pulse);
                default: ;
            endcase
        end

        if ((state_q == SET_S) && (state_d == ALM_H)) begin
            load_d       = 1'b1;
            load_value_d = edit_q;
        end

        if ((state_d != state_q) || step_acc) begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_off_d = !blink_off_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end

        // While ringing, alarm_pulse is only an acknowledge.
        if ((state_q == RUN) && alarm_pulse && !alarm_active_q) begin
            alarm_en_d = !alarm_en_q;
        end

        // Any pulse suppresses a coincident fire so the state change wins.
        if (alarm_active_q) begin
            if (any_pulse || (state_d != RUN) || !alarm_en_d) begin
                alarm_active_d = 1'b0;
            end else if (sec_chg) begin
                if (sec_cnt_q == SEC_LAST) begin
                    alarm_active_d = 1'b0;
                end else begin
                    sec_cnt_d = sec_cnt_q + 1'b1;
                end
            end
        end else if ((state_q == RUN) && alarm_en_q && match && !any_pulse) begin
            alarm_active_d = 1'b1;
            sec_cnt_d      = '0;
        end
    end

    // Registered outputs derived from the next-state values.
    always_comb begin
        run_en_d     = 1'b1;
        disp_value_d = time_in;
        blank_mask_d = '0;
        case (state_d)
            SET_H: begin
                run_en_d     = 1'b0;
                disp_value_d = edit_d;
                if (blink_off_d) blank_mask_d = 6'b110000;
            end
            SET_M: begin
                run_en_d     = 1'b0;
                disp_value_d = edit_d;
                if (blink_off_d) blank_mask_d = 6'b001100;
            end
            SET_S: begin
                run_en_d     = 1'b0;
                disp_value_d = edit_d;
                if (blink_off_d) blank_mask_d = 6'b000011;
            end
            ALM_H: begin
                disp_value_d = {alarm_h_d, alarm_m_d, 8'd0};
                blank_mask_d = blink_off_d ? 6'b110011 : 6'b000011;
            end
            ALM_M: begin
                disp_value_d = {alarm_h_d, alarm_m_d, 8'd0};
                blank_mask_d = blink_off_d ? 6'b001111 : 6'b000011;
            end
            default: ;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RUN;
            edit_q         <= '0;
            alarm_h_q      <= '0;
            alarm_m_q      <= '0;
            alarm_en_q     <= 1'b0;
            alarm_active_q <= 1'b0;
            sec_cnt_q      <= '0;
            blink_cnt_q    <= '0;
            blink_off_q    <= 1'b0;
            prev_time_q    <= '0;
            run_en_q       <= 1'b1;
            load_q         <= 1'b0;
            load_value_q   <= '0;
            disp_value_q   <= '0;
            blank_mask_q   <= '0;
        end else begin
            state_q        <= state_d;
            edit_q         <= edit_d;
            alarm_h_q      <= alarm_h_d;
            alarm_m_q      <= alarm_m_d;
            alarm_en_q     <= alarm_en_d;
            alarm_active_q <= alarm_active_d;
            sec_cnt_q      <= sec_cnt_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_off_q    <= blink_off_d;
            prev_time_q    <= prev_time_d;
            run_en_q       <= run_en_d;
            load_q         <= load_d;
            load_value_q   <= load_value_d;
            disp_value_q   <= disp_value_d;
            blank_mask_q   <= blank_mask_d;
        end
    end

    assign run_en       = run_en_q;
    assign load         = load_q;
    assign load_value   = load_value_q;
    assign disp_value   = disp_value_q;
    assign blank_mask   = blank_mask_q;
    assign alarm_en     = alarm_en_q;
    assign alarm_active = alarm_active_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short blink and alarm periods.
module tb_time_set_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode_pulse = 1'b0;
    logic        up_pulse = 1'b0;
    logic        down_pulse = 1'b0;
    logic        alarm_pulse = 1'b0;
    logic [23:0] time_in = 24'h0C1E05;
    logic        run_en;
    logic        load;
    logic [23:0] load_value;
    logic [23:0] disp_value;
    logic [5:0]  blank_mask;
    logic        alarm_en;
    logic        alarm_active;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned load_cnt = 0;

    time_set_ctrl #(
        .BLINK_HALF(4),
        .ALARM_SEC (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode_pulse  (mode_pulse),
        .up_pulse    (up_pulse),
        .down_pulse  (down_pulse),
        .alarm_pulse (alarm_pulse),
        .time_in     (time_in),
        .run_en      (run_en),
        .load        (load),
        .load_value  (load_value),
        .disp_value  (disp_value),
        .blank_mask  (blank_mask),
        .alarm_en    (alarm_en),
        .alarm_active(alarm_active)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (load === 1'b1) load_cnt++;

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic m, input logic u, input logic d, input logic a);
        mode_pulse  = m;
        up_pulse    = u;
        down_pulse  = d;
        alarm_pulse = a;
        tick();
        mode_pulse  = 1'b0;
        up_pulse    = 1'b0;
        down_pulse  = 1'b0;
        alarm_pulse = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_run_en", 24'(run_en), 24'd1);
        check("rst_load", 24'(load), 24'd0);
        check("rst_disp", disp_value, 24'h000000);
        check("rst_mask", 24'(blank_mask), 24'd0);
        check("rst_alarm_en", 24'(alarm_en), 24'd0);
        rst = 1'b0;
        tick();
        check("run_disp", disp_value, 24'h0C1E05);
        check("run_en", 24'(run_en), 24'd1);
        check("run_load", 24'(load), 24'd0);
        check("run_mask", 24'(blank_mask), 24'd0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("run_up_ignored", disp_value, 24'h0C1E05);

        // Edit sequence with wraps and one load
        time_in = 24'h173B3B;
        tick();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("seth_run_en", 24'(run_en), 24'd0);
        check("seth_disp", disp_value, 24'h173B3B);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("seth_wrap", disp_value, 24'h003B3B);
        check("seth_run_en2", 24'(run_en), 24'd0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("setm_down", disp_value, 24'h003A3B);
        check("setm_run_en", 24'(run_en), 24'd0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("sets_wrap", disp_value, 24'h003A00);
        check("sets_run_en", 24'(run_en), 24'd0);
        check("sets_no_load", 24'(load_cnt), 24'd0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("load_pulse", 24'(load), 24'd1);
        check("load_value", load_value, 24'h003A00);
        check("load_run_en", 24'(run_en), 24'd1);
        tick();
        check("load_drop", 24'(load), 24'd0);
        check("load_count", 24'(load_cnt), 24'd1);

        // Alarm 07:30
        for (int i = 0; i < 7; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("almh_disp", disp_value, 24'h070000);
        check("almh_mask", 24'(blank_mask), 24'h000003);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("almm_disp", disp_value, 24'h071E00);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("back_run_disp", disp_value, 24'h173B3B);
        check("back_run_en", 24'(run_en), 24'd1);
        check("arm_before", 24'(alarm_en), 24'd0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("arm_after", 24'(alarm_en), 24'd1);

        // Fire and timeout after three seconds changes
        time_in = 24'h071D3B;
        tick();
        check("pre_match", 24'(alarm_active), 24'd0);
        time_in = 24'h071E00;
        tick();
        check("fire", 24'(alarm_active), 24'd1);
        tick();
        check("fire_hold", 24'(alarm_active), 24'd1);
        time_in = 24'h071E01;
        tick();
        check("sec1", 24'(alarm_active), 24'd1);
        time_in = 24'h071E02;
        tick();
        check("sec2", 24'(alarm_active), 24'd1);
        time_in = 24'h071E03;
        tick();
        check("sec3_clear", 24'(alarm_active), 24'd0);

        // Down pulse acknowledges; holding the match does not refire
        time_in = 24'h071D3B;
        tick();
        time_in = 24'h071E00;
        tick();
        check("refire", 24'(alarm_active), 24'd1);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("down_ack", 24'(alarm_active), 24'd0);
        check("down_ack_en", 24'(alarm_en), 24'd1);
        tick();
        tick();
        tick();
        check("no_refire", 24'(alarm_active), 24'd0);

        // alarm_pulse while ringing only acknowledges
        time_in = 24'h071D3B;
        tick();
        time_in = 24'h071E00;
        tick();
        check("fire3", 24'(alarm_active), 24'd1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("alm_ack", 24'(alarm_active), 24'd0);
        check("alm_ack_en", 24'(alarm_en), 24'd1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("disarm", 24'(alarm_en), 24'd0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("rearm", 24'(alarm_en), 24'd1);

        // Mode pulse coinciding with a match
        time_in = 24'h071D3B;
        tick();
        time_in = 24'h071E00;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("mode_wins_act", 24'(alarm_active), 24'd0);
        check("mode_wins_run_en", 24'(run_en), 24'd0);
        check("mode_wins_disp", disp_value, 24'h071E00);

        // Reset in SET_S discards the edit
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("sets2_disp", disp_value, 24'h071E01);
        rst = 1'b1;
        #1;
        check("mid_rst_run_en", 24'(run_en), 24'd1);
        check("mid_rst_alarm_en", 24'(alarm_en), 24'd0);
        check("mid_rst_disp", disp_value, 24'h000000);
        tick();
        rst = 1'b0;
        time_in = 24'h0C1E05;
        tick();
        check("post_rst_run_en", 24'(run_en), 24'd1);
        check("post_rst_disp", disp_value, 24'h0C1E05);
        check("post_rst_load_cnt", 24'(load_cnt), 24'd1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("post_rst_edit", disp_value, 24'h0C1E05);

        // Blink in SET_M, BLINK_HALF = 4
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("blink_k0", 24'(blank_mask), 24'h000000);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("blink_k%0d", k), 24'(blank_mask),
                  ((k >= 4) && (k < 8)) ? 24'h00000C : 24'h000000);
        end
        for (int k = 9; k <= 12; k++) tick();
        check("blink_off_again", 24'(blank_mask), 24'h00000C);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("blink_up_on", 24'(blank_mask), 24'h000000);
        check("blink_up_disp", disp_value, 24'h0C1F05);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("blink_up_k%0d", k), 24'(blank_mask),
                  (k == 4) ? 24'h00000C : 24'h000000);
        end
        check("final_load_cnt", 24'(load_cnt), 24'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
